// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - shared 74HC595 link definitions (state encoding, word layout)
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 16;

  // Bit counter width; the counter saturates at its all-ones value.
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_SAT = 6'd63;

  // Display word as driven by the transmit side: {1, seg[6:0], 0000, sel[3:0]}.
  typedef struct packed {
    logic       one;
    logic [6:0] seg;
    logic [3:0] pad;
    logic [3:0] sel;
  } word_t;

  function automatic word_t pack_word(input logic [6:0] seg, input logic [3:0] sel);
    word_t w;
    w.one = 1'b1;
    w.seg = seg;
    w.pad = 4'b0000;
    w.sel = sel;
    return w;
  endfunction

endpackage

// File: rtl/hc595_pin_sync.sv
// rtl/hc595_pin_sync.sv - multi-flop pin synchronizer with rising-edge detect
module hc595_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one delayed copy of the synchronized level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hc595_rx.sv
// rtl/hc595_rx.sv - 74HC595 serial link receiver; HC595_RX_FRAME_CHECK_EN enables frame_err
module hc595_rx
  import hc595_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_TO     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sh_cp,
  input  logic              st_cp,
  input  logic              ds,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int WARM_N = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM_N + 1);
  localparam int TO_W   = $clog2(IDLE_TO + 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt, cnt_inc;
  logic [TO_W-1:0]   idle_cnt;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done, timeout;
  logic              sh_rise_raw, st_rise_raw, sh_rise, st_rise;
  logic              sh_lvl_unused, st_lvl_unused, ds_rise_unused;
  logic              ds_s;

  hc595_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sh (
    .clk(clk), .rst(rst), .pin(sh_cp), .level(sh_lvl_unused), .rise(sh_rise_raw)
  );
  hc595_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_st (
    .clk(clk), .rst(rst), .pin(st_cp), .level(st_lvl_unused), .rise(st_rise_raw)
  );
  hc595_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .clk(clk), .rst(rst), .pin(ds), .level(ds_s), .rise(ds_rise_unused)
  );

  // Warm-up: mask edges until the synchronizers hold real pin values, so a pin high at release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
  end

  assign warm_done = (warm_cnt == WARM_W'(WARM_N));
  assign sh_rise   = sh_rise_raw & warm_done;
  assign st_rise   = st_rise_raw & warm_done;
  assign timeout   = (idle_cnt == TO_W'(IDLE_TO - 1));
  assign cnt_inc   = (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: latch wins, except a coincident shift restarts a frame with its one new bit
  always_comb begin
    state_nxt = state;
    if (st_rise)                          state_nxt = sh_rise ? SHIFT : IDLE;
    else if (sh_rise)                     state_nxt = (cnt_inc >= CNT_W'(DATA_W)) ? FULL : SHIFT;
    else if (state != IDLE && timeout)    state_nxt = IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
  end

  // Idle timer: cycles since the last shift edge while a frame is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                idle_cnt <= '0;
    else if (sh_rise || state == IDLE)      idle_cnt <= '0;
    else if (!timeout)                      idle_cnt <= idle_cnt + 1'b1;
  end

  // Shift register and bit counter; an abandoned frame keeps shreg but restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (sh_rise) shreg <= {shreg[DATA_W-2:0], ds_s};
      if (st_rise)                     bit_cnt <= sh_rise ? CNT_W'(1) : '0;
      else if (sh_rise)                bit_cnt <= cnt_inc;
      else if (state != IDLE && timeout) bit_cnt <= '0;
    end
  end

  // Latch the pre-shift word on st_cp rise, pulsing data_valid with the update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= st_rise;
      if (st_rise) data_out <= shreg;
    end
  end

`ifdef HC595_RX_FRAME_CHECK_EN
  // Flag a latch whose frame did not carry exactly DATA_W bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= st_rise && (bit_cnt != CNT_W'(DATA_W));
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_rx.sv
// tb/tb_hc595_rx.sv - directed scoreboard bench for hc595_rx
module tb_hc595_rx;

  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int IDLE_TO     = 1024;
  localparam int HALF        = 3;

`ifdef HC595_RX_FRAME_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sh_cp = 1'b0, st_cp = 1'b0, ds = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, busy, frame_err;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              e;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   dv_count = 0;

  hc595_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .rst(rst), .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each data_valid pulse consumes one expected word
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      dv_count++;
      if (sb.size() == 0) begin
        check("dv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("data_out", 32'(data_out), 32'(x.d));
        check("frame_err", 32'(frame_err), 32'(x.e));
      end
    end
    if (!rst && frame_err && !data_valid) check("frame_err_alone", 32'd1, 32'd0);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    wait_clks(HALF);
    sh_cp = 1'b1;
    wait_clks(HALF);
    sh_cp = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch();
    st_cp = 1'b1;
    wait_clks(HALF);
    st_cp = 1'b0;
    wait_clks(HALF + 2);
  endtask

  // Latch and count clocks from the pin edge to the data_valid pulse (bounded)
  task automatic latch_measure(output int lat);
    lat = -1;
    st_cp = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (data_valid && lat < 0) lat = k;
      if (k == HALF) st_cp = 1'b0;
    end
  endtask

  initial begin
    int dv0, lat;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);

    // 1: basic frame
    dv0 = dv_count;
    shift_word(32'hA5C3, 16);
    check("t1_busy_during", 32'(busy), 32'h1);
    sb.push_back('{d: 16'hA5C3, e: 1'b0});
    latch();
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_dv_count", 32'(dv_count - dv0), 32'd1);

    // 2: repeated frames at transmit-driver pacing, latency check
    sb.push_back('{d: 16'hF30E, e: 1'b0});
    shift_word(32'hF30E, 16);
    latch();
    sb.push_back('{d: 16'hF30E, e: 1'b0});
    shift_word(32'hF30E, 16);
    latch_measure(lat);
    check("t2_latency", 32'(lat), 32'(SYNC_STAGES + 1));
    wait_clks(3);

    // 3: short frame, then overlong frame
    sb.push_back('{d: 16'hEABC, e: ERR_ON});
    shift_word(32'hABC, 12);
    latch();
    sb.push_back('{d: 16'h2345, e: ERR_ON});
    shift_word(32'h12345, 20);
    check("t3_busy_full", 32'(busy), 32'h1);
    latch();

    // 4: coincident shift and latch edges
    shift_word(32'h1234, 16);
    sb.push_back('{d: 16'h1234, e: 1'b0});
    ds = 1'b1;
    wait_clks(HALF);
    sh_cp = 1'b1;
    st_cp = 1'b1;
    wait_clks(HALF);
    sh_cp = 1'b0;
    st_cp = 1'b0;
    wait_clks(HALF);
    check("t4_bit_cnt", 32'(dut.bit_cnt), 32'd1);
    check("t4_state", 32'(dut.state), 32'd1);
    check("t4_busy", 32'(busy), 32'h1);

    // 5: stalled frame times out silently, then a clean frame
    dv0 = dv_count;
    shift_word(32'h55, 7);
    wait_clks(IDLE_TO - 4);
    check("t5_busy_before_to", 32'(busy), 32'h1);
    wait_clks(1);
    check("t5_busy_at_to", 32'(busy), 32'h0);
    wait_clks(5);
    check("t5_no_dv", 32'(dv_count - dv0), 32'd0);
    sb.push_back('{d: 16'h00FF, e: 1'b0});
    shift_word(32'h00FF, 16);
    latch();

    // 6: pins high through reset release, then mid-frame reset
    dv0 = dv_count;
    rst = 1'b1;
    sh_cp = 1'b1;
    st_cp = 1'b1;
    ds = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(10);
    check("t6_hold_no_dv", 32'(dv_count - dv0), 32'd0);
    check("t6_hold_busy", 32'(busy), 32'h0);
    check("t6_hold_data", 32'(data_out), 32'h0);
    sh_cp = 1'b0;
    st_cp = 1'b0;
    ds = 1'b0;
    wait_clks(5);
    sb.push_back('{d: 16'hC3A5, e: 1'b0});
    shift_word(32'hC3A5, 16);
    latch();
    shift_word(32'h1AB, 9);
    rst = 1'b1;
    wait_clks(2);
    check("t6_rst_data", 32'(data_out), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_dv", 32'(data_valid), 32'h0);
    check("t6_rst_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    wait_clks(5);
    sb.push_back('{d: 16'hBEEF, e: 1'b0});
    shift_word(32'hBEEF, 16);
    latch();
    sb.push_back('{d: 16'hBEEF, e: ERR_ON});
    latch();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
